// File: rtl/dap_swd_target.sv
// SWD target engine: oversamples host SWCLK/SWDIO, decodes request packets,
// returns ACK/read data from a register backend and captures write data.
module dap_swd_target #(
  parameter int LINE_RESET_BITS = 50
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        SWCLK_I,
  input  logic        SWDIO_I,
  output logic        SWDIO_O,
  output logic        SWDIO_T,
  output logic        req_valid,
  output logic        req_apndp,
  output logic        req_rnw,
  output logic [1:0]  req_addr,
  input  logic        resp_valid,
  input  logic [2:0]  resp_ack,
  input  logic [31:0] resp_rdata,
  output logic        wr_valid,
  output logic [31:0] wr_data,
  output logic        wr_perr,
  output logic        proto_err,
  output logic        line_reset
);
  localparam int LRW = $clog2(LINE_RESET_BITS + 1);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_ACK, S_RDATA, S_WDATA, S_END} state_t;

  state_t state_reg, state_next;
  logic swclk_s1_reg, swclk_s2_reg, swclk_s3_reg, dio_s1_reg, dio_s2_reg;
  logic [5:0]     cnt_reg, cnt_next, edge_n;
  logic [6:0]     hdr_reg, hdr_next, hdr_shift;
  logic [2:0]     ack_reg, ack_next, ack_sel;
  logic [31:0]    rd_reg, rd_next, wd_reg, wd_next, wr_data_reg, wr_data_next;
  logic           par_reg, par_next, wr_perr_reg, wr_perr_next;
  logic [LRW-1:0] lr_cnt_reg, lr_cnt_next;
  logic           armed_reg, armed_next, lr_fire;
  logic           swdio_o_reg, swdio_o_next, swdio_t_reg, swdio_t_next;
  logic           req_apndp_reg, req_apndp_next, req_rnw_reg, req_rnw_next;
  logic [1:0]     req_addr_reg, req_addr_next;
  logic           req_valid_reg, req_valid_next, wr_valid_reg, wr_valid_next;
  logic           proto_err_reg, proto_err_next, line_reset_reg, line_reset_next;
  logic           edge_det, dio;

  assign edge_det = swclk_s2_reg & ~swclk_s3_reg;
  assign dio      = dio_s2_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      swclk_s1_reg <= 1'b0; swclk_s2_reg <= 1'b0; swclk_s3_reg <= 1'b0;
      dio_s1_reg   <= 1'b0; dio_s2_reg   <= 1'b0;
      state_reg <= S_IDLE; cnt_reg <= '0; hdr_reg <= '0; ack_reg <= '0;
      rd_reg <= '0; par_reg <= 1'b0; wd_reg <= '0; lr_cnt_reg <= '0; armed_reg <= 1'b1;
      swdio_o_reg <= 1'b0; swdio_t_reg <= 1'b1;
      req_apndp_reg <= 1'b0; req_rnw_reg <= 1'b0; req_addr_reg <= '0;
      wr_data_reg <= '0; wr_perr_reg <= 1'b0;
      req_valid_reg <= 1'b0; wr_valid_reg <= 1'b0; proto_err_reg <= 1'b0; line_reset_reg <= 1'b0;
    end else begin
      swclk_s1_reg <= SWCLK_I; swclk_s2_reg <= swclk_s1_reg; swclk_s3_reg <= swclk_s2_reg;
      dio_s1_reg   <= SWDIO_I; dio_s2_reg   <= dio_s1_reg;
      state_reg <= state_next; cnt_reg <= cnt_next; hdr_reg <= hdr_next; ack_reg <= ack_next;
      rd_reg <= rd_next; par_reg <= par_next; wd_reg <= wd_next;
      lr_cnt_reg <= lr_cnt_next; armed_reg <= armed_next;
      swdio_o_reg <= swdio_o_next; swdio_t_reg <= swdio_t_next;
      req_apndp_reg <= req_apndp_next; req_rnw_reg <= req_rnw_next; req_addr_reg <= req_addr_next;
      wr_data_reg <= wr_data_next; wr_perr_reg <= wr_perr_next;
      req_valid_reg <= req_valid_next; wr_valid_reg <= wr_valid_next;
      proto_err_reg <= proto_err_next; line_reset_reg <= line_reset_next;
    end
  end

  always_comb begin
    state_next = state_reg;     cnt_next = cnt_reg;         hdr_next = hdr_reg;
    ack_next = ack_reg;         rd_next = rd_reg;           par_next = par_reg;
    wd_next = wd_reg;           lr_cnt_next = lr_cnt_reg;   armed_next = armed_reg;
    swdio_o_next = swdio_o_reg; swdio_t_next = swdio_t_reg;
    req_apndp_next = req_apndp_reg; req_rnw_next = req_rnw_reg; req_addr_next = req_addr_reg;
    wr_data_next = wr_data_reg; wr_perr_next = wr_perr_reg;
    req_valid_next = 1'b0; wr_valid_next = 1'b0; proto_err_next = 1'b0; line_reset_next = 1'b0;
    lr_fire   = 1'b0;
    hdr_shift = {dio, hdr_reg[6:1]};
    ack_sel   = resp_valid ? resp_ack : 3'b010;
    edge_n    = cnt_reg + 6'd1;
    if (edge_det) begin
      cnt_next = edge_n;
      // The run-of-ones counter only observes the line while the host owns it.
      if (swdio_t_reg) begin
        if (dio) begin
          if (lr_cnt_reg != LRW'(LINE_RESET_BITS)) lr_cnt_next = lr_cnt_reg + LRW'(1);
          lr_fire = (lr_cnt_reg == LRW'(LINE_RESET_BITS - 1));
        end else begin
          lr_cnt_next = '0;
          armed_next  = 1'b1;
        end
      end
      if (lr_fire) begin
        state_next = S_IDLE; swdio_t_next = 1'b1; swdio_o_next = 1'b0;
        line_reset_next = 1'b1; armed_next = 1'b0;
      end else begin
        case (state_reg)
          S_IDLE: begin
            cnt_next = '0;
            if (dio && armed_reg) begin
              state_next = S_REQ;
              cnt_next   = 6'd1;
            end
          end
          S_REQ: begin
            hdr_next = hdr_shift;
            // hdr_shift: [0]APnDP [1]RnW [2]A2 [3]A3 [4]parity [5]stop [6]park
            if (edge_n == 6'd8) begin
              if (!(^hdr_shift[4:0]) && !hdr_shift[5] && hdr_shift[6]) begin
                req_apndp_next = hdr_shift[0];
                req_rnw_next   = hdr_shift[1];
                req_addr_next  = {hdr_shift[3], hdr_shift[2]};
                req_valid_next = 1'b1;
                state_next     = S_ACK;
              end else begin
                proto_err_next = 1'b1;
                state_next     = S_IDLE;
              end
            end
          end
          S_ACK: begin
            if (edge_n == 6'd9) begin
              ack_next = ack_sel; rd_next = resp_rdata; par_next = ^resp_rdata;
              swdio_t_next = 1'b0; swdio_o_next = ack_sel[0];
            end else if (edge_n == 6'd10) begin
              swdio_o_next = ack_reg[1];
            end else if (edge_n == 6'd11) begin
              swdio_o_next = ack_reg[2];
            end else begin
              if (ack_reg == 3'b001 && req_rnw_reg) begin
                swdio_o_next = rd_reg[0]; rd_next = rd_reg >> 1; state_next = S_RDATA;
              end else begin
                swdio_t_next = 1'b1; swdio_o_next = 1'b0;
                state_next = (ack_reg == 3'b001) ? S_WDATA : S_END;
              end
            end
          end
          S_RDATA: begin
            if (edge_n <= 6'd43) begin
              swdio_o_next = rd_reg[0]; rd_next = rd_reg >> 1;
            end else if (edge_n == 6'd44) begin
              swdio_o_next = par_reg;
            end else if (edge_n == 6'd45) begin
              swdio_t_next = 1'b1; swdio_o_next = 1'b0;
            end else begin
              state_next = S_IDLE; cnt_next = '0;
            end
          end
          S_WDATA: begin
            if (edge_n >= 6'd14 && edge_n <= 6'd45) begin
              wd_next = {dio, wd_reg[31:1]};
            end else if (edge_n == 6'd46) begin
              wr_data_next = wd_reg; wr_perr_next = ^{wd_reg, dio};
              wr_valid_next = 1'b1; state_next = S_IDLE; cnt_next = '0;
            end
          end
          default: begin
            state_next = S_IDLE; cnt_next = '0;
          end
        endcase
      end
    end
  end

  assign SWDIO_O    = swdio_o_reg;
  assign SWDIO_T    = swdio_t_reg;
  assign req_valid  = req_valid_reg;
  assign req_apndp  = req_apndp_reg;
  assign req_rnw    = req_rnw_reg;
  assign req_addr   = req_addr_reg;
  assign wr_valid   = wr_valid_reg;
  assign wr_data    = wr_data_reg;
  assign wr_perr    = wr_perr_reg;
  assign proto_err  = proto_err_reg;
  assign line_reset = line_reset_reg;
endmodule

// File: tb/tb_dap_swd_target.sv
// Directed bench for dap_swd_target: plays the SWD host bit by bit and acts
// as a static register backend.
module tb_dap_swd_target;
  logic        clk = 1'b0, reset = 1'b1, SWCLK_I = 1'b0, SWDIO_I = 1'b0;
  logic        SWDIO_O, SWDIO_T, req_valid, req_apndp, req_rnw;
  logic [1:0]  req_addr;
  logic        resp_valid = 1'b0;
  logic [2:0]  resp_ack = 3'b001;
  logic [31:0] resp_rdata = 32'h0;
  logic        wr_valid, wr_perr, proto_err, line_reset;
  logic [31:0] wr_data;

  int errors = 0, checks = 0;
  int n_req = 0, n_wr = 0, n_perr = 0, n_lr = 0, n_tlow = 0, edge_idx = 0, lr_edge = -1;

  always #5 clk = ~clk;

  dap_swd_target #(.LINE_RESET_BITS(50)) dut (
    .clk(clk), .reset(reset), .SWCLK_I(SWCLK_I), .SWDIO_I(SWDIO_I),
    .SWDIO_O(SWDIO_O), .SWDIO_T(SWDIO_T),
    .req_valid(req_valid), .req_apndp(req_apndp), .req_rnw(req_rnw), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_ack(resp_ack), .resp_rdata(resp_rdata),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_perr(wr_perr),
    .proto_err(proto_err), .line_reset(line_reset)
  );

  // Pulse monitors: a pulse wider than one clk is counted more than once.
  always @(posedge clk) begin
    if (req_valid)  n_req  <= n_req + 1;
    if (wr_valid)   n_wr   <= n_wr + 1;
    if (proto_err)  n_perr <= n_perr + 1;
    if (line_reset) begin n_lr <= n_lr + 1; lr_edge <= edge_idx; end
    if (!SWDIO_T)   n_tlow <= n_tlow + 1;
  end

  // One SWCLK period (16 clk); returns 8 clk after the rising edge.
  task automatic host_bit(input logic b);
    SWDIO_I = b;
    repeat (8) @(negedge clk);
    SWCLK_I = 1'b1;
    edge_idx = edge_idx + 1;
    repeat (8) @(negedge clk);
    SWCLK_I = 1'b0;
  endtask

  task automatic send_req(input logic [7:0] r);
    for (int i = 0; i < 8; i++) host_bit(r[i]);
  endtask

  // Edges 9..11: target drives ACK LSB first.
  task automatic get_ack(output logic [2:0] ack, output int t_bad);
    logic [2:0] v;
    t_bad = 0;
    for (int i = 0; i < 3; i++) begin
      host_bit(1'b0);
      v[i] = SWDIO_O;
      if (SWDIO_T !== 1'b0) t_bad++;
    end
    ack = v;
  endtask

  // Edges 12..44: 32 data bits then parity.
  task automatic get_rdata(output logic [31:0] d, output logic p, output int t_bad);
    logic [31:0] v;
    t_bad = 0;
    for (int i = 0; i < 32; i++) begin
      host_bit(1'b0);
      v[i] = SWDIO_O;
      if (SWDIO_T !== 1'b0) t_bad++;
    end
    host_bit(1'b0);
    p = SWDIO_O;
    if (SWDIO_T !== 1'b0) t_bad++;
    d = v;
  endtask

  task automatic full_read(input string nm, input logic [31:0] exp_d, input logic exp_p);
    logic [2:0] ack; logic [31:0] d; logic p; int tb;
    get_ack(ack, tb);
    checks++;
    if (ack !== 3'b001 || tb != 0) begin
      errors++; $display("FAIL %s_ack got=%b tbad=%0d exp=001", nm, ack, tb);
    end
    get_rdata(d, p, tb);
    checks++;
    if (d !== exp_d || p !== exp_p || tb != 0) begin
      errors++; $display("FAIL %s_data got=%h/%b tbad=%0d exp=%h/%b", nm, d, p, tb, exp_d, exp_p);
    end
    host_bit(1'b0);
    checks++;
    if (SWDIO_T !== 1'b1) begin
      errors++; $display("FAIL %s_release got T=%b exp=1", nm, SWDIO_T);
    end
    host_bit(1'b0);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if ({SWDIO_T, SWDIO_O, req_valid, wr_valid, proto_err, line_reset} !== 6'b100000) begin
      errors++; $display("FAIL reset_line_pulses got=%b exp=100000",
                         {SWDIO_T, SWDIO_O, req_valid, wr_valid, proto_err, line_reset});
    end
    checks++;
    if ({req_apndp, req_rnw, req_addr, wr_perr} !== 5'b0 || wr_data !== 32'h0) begin
      errors++; $display("FAIL reset_held got=%b/%h exp=0/0",
                         {req_apndp, req_rnw, req_addr, wr_perr}, wr_data);
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_read;
    int r0;
    resp_valid = 1'b1; resp_ack = 3'b001; resp_rdata = 32'h12345678;
    r0 = n_req;
    send_req(8'h8D);
    checks++;
    if (n_req - r0 != 1 || req_addr !== 2'b01 || req_rnw !== 1'b1 || req_apndp !== 1'b0) begin
      errors++; $display("FAIL read_req got=%0d/%b%b%b exp=1/0101", n_req - r0, req_apndp, req_rnw, req_addr);
    end
    full_read("read", 32'h12345678, 1'b1);
  endtask

  task automatic test_write(input logic par, input logic exp_perr);
    logic [2:0] ack; int tb, w0; logic [31:0] wd;
    resp_valid = 1'b1; resp_ack = 3'b001;
    wd = 32'hDEADBEEF;
    w0 = n_wr;
    send_req(8'hA3);
    checks++;
    if (req_apndp !== 1'b1 || req_rnw !== 1'b0 || req_addr !== 2'b00) begin
      errors++; $display("FAIL write_req got=%b%b%b exp=1000", req_apndp, req_rnw, req_addr);
    end
    get_ack(ack, tb);
    checks++;
    if (ack !== 3'b001 || tb != 0) begin
      errors++; $display("FAIL write_ack got=%b tbad=%0d exp=001", ack, tb);
    end
    host_bit(1'b0);
    checks++;
    if (SWDIO_T !== 1'b1) begin
      errors++; $display("FAIL write_release got T=%b exp=1", SWDIO_T);
    end
    host_bit(1'b0);
    for (int i = 0; i < 32; i++) host_bit(wd[i]);
    host_bit(par);
    checks++;
    if (n_wr - w0 != 1 || wr_data !== 32'hDEADBEEF || wr_perr !== exp_perr) begin
      errors++; $display("FAIL write_p%0b got=%0d/%h/%b exp=1/deadbeef/%b",
                         par, n_wr - w0, wr_data, wr_perr, exp_perr);
    end
  endtask

  task automatic test_proto;
    logic [2:0] ack; int tb, t0, p0, r0;
    t0 = n_tlow; p0 = n_perr; r0 = n_req;
    send_req(8'h85);
    checks++;
    if (n_perr - p0 != 1 || n_req != r0) begin
      errors++; $display("FAIL proto_parity got=%0d/%0d exp=1/0", n_perr - p0, n_req - r0);
    end
    send_req(8'hE5);
    checks++;
    if (n_perr - p0 != 2 || n_req != r0 || n_tlow != t0) begin
      errors++; $display("FAIL proto_stop got=%0d/%0d tlow=%0d exp=2/0/0",
                         n_perr - p0, n_req - r0, n_tlow - t0);
    end
    resp_valid = 1'b0;
    send_req(8'hA5);
    checks++;
    if (n_req - r0 != 1) begin
      errors++; $display("FAIL proto_recover got=%0d exp=1", n_req - r0);
    end
    get_ack(ack, tb);
    host_bit(1'b0);
    host_bit(1'b0);
  endtask

  task automatic test_wait;
    logic [2:0] ack; int tb, w0;
    resp_valid = 1'b0; resp_ack = 3'b001;
    w0 = n_wr;
    send_req(8'hA5);
    checks++;
    if (req_addr !== 2'b00 || req_rnw !== 1'b1 || req_apndp !== 1'b0) begin
      errors++; $display("FAIL wait_req got=%b%b%b exp=0100", req_apndp, req_rnw, req_addr);
    end
    get_ack(ack, tb);
    checks++;
    if (ack !== 3'b010 || tb != 0) begin
      errors++; $display("FAIL wait_ack got=%b tbad=%0d exp=010", ack, tb);
    end
    host_bit(1'b0);
    checks++;
    if (SWDIO_T !== 1'b1 || n_wr != w0) begin
      errors++; $display("FAIL wait_release got T=%b wr=%0d exp=1/0", SWDIO_T, n_wr - w0);
    end
    host_bit(1'b0);
  endtask

  task automatic test_back_to_back;
    int r0;
    resp_valid = 1'b1; resp_ack = 3'b001; resp_rdata = 32'h80000001;
    r0 = n_req;
    send_req(8'h8D);
    checks++;
    if (n_req - r0 != 1) begin
      errors++; $display("FAIL b2b_req got=%0d exp=1", n_req - r0);
    end
    full_read("b2b", 32'h80000001, 1'b0);
  endtask

  task automatic test_line_reset;
    logic [2:0] ack; int tb, l0, p0, w0, base;
    host_bit(1'b0);
    l0 = n_lr; p0 = n_perr;
    for (int i = 0; i < 49; i++) host_bit(1'b1);
    for (int i = 0; i < 7; i++) host_bit(1'b0);
    checks++;
    if (n_lr != l0 || n_perr - p0 != 7) begin
      errors++; $display("FAIL lr_49ones got lr=%0d perr=%0d exp=0/7", n_lr - l0, n_perr - p0);
    end
    // Write with all-ones data running on into a line reset.
    resp_valid = 1'b1; resp_ack = 3'b001;
    w0 = n_wr;
    send_req(8'hA3);
    p0 = n_perr;
    get_ack(ack, tb);
    host_bit(1'b0);
    host_bit(1'b0);
    host_bit(1'b0);
    base = edge_idx;
    for (int i = 0; i < 32; i++) host_bit(1'b1);
    checks++;
    if (n_wr - w0 != 1 || wr_data !== 32'hFFFFFFFE || wr_perr !== 1'b0) begin
      errors++; $display("FAIL lr_write got=%0d/%h/%b exp=1/fffffffe/0", n_wr - w0, wr_data, wr_perr);
    end
    for (int i = 0; i < 25; i++) host_bit(1'b1);
    checks++;
    if (n_lr - l0 != 1 || lr_edge != base + 50) begin
      errors++; $display("FAIL lr_50ones got n=%0d edge=%0d exp=1/%0d", n_lr - l0, lr_edge, base + 50);
    end
    checks++;
    if (n_perr - p0 != 2 || SWDIO_T !== 1'b1) begin
      errors++; $display("FAIL lr_abort got perr=%0d T=%b exp=2/1", n_perr - p0, SWDIO_T);
    end
    host_bit(1'b0);
    host_bit(1'b0);
  endtask

  task automatic test_reset_midread;
    logic [2:0] ack; logic [31:0] d; logic p; int tb, r0;
    resp_valid = 1'b1; resp_ack = 3'b001; resp_rdata = 32'h12345678;
    send_req(8'h8D);
    get_ack(ack, tb);
    for (int i = 0; i < 8; i++) host_bit(1'b0);
    checks++;
    if (SWDIO_T !== 1'b0) begin
      errors++; $display("FAIL rst_pre got T=%b exp=0", SWDIO_T);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (SWDIO_T !== 1'b1 || SWDIO_O !== 1'b0 || req_addr !== 2'b00) begin
      errors++; $display("FAIL rst_mid got T=%b O=%b addr=%b exp=1/0/00", SWDIO_T, SWDIO_O, req_addr);
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    resp_rdata = 32'h00000007;
    r0 = n_req;
    send_req(8'h8D);
    checks++;
    if (n_req - r0 != 1 || req_addr !== 2'b01) begin
      errors++; $display("FAIL rst_fresh_req got=%0d/%b exp=1/01", n_req - r0, req_addr);
    end
    full_read("rst_fresh", 32'h00000007, 1'b1);
    d = 32'h0; p = 1'b0;
  endtask

  initial begin
    test_reset();
    test_read();
    test_write(1'b0, 1'b0);
    test_write(1'b1, 1'b1);
    test_proto();
    test_wait();
    test_back_to_back();
    test_line_reset();
    test_reset_midread();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
